// File: rtl/iob_regfile_dp_bist_pkg.sv
// Shared state and phase encodings for the dual-port regfile BIST.
package iob_regfile_dp_bist_pkg;

  localparam int I_IDLE = 0;
  localparam int I_AWR  = 1;
  localparam int I_ARD  = 2;
  localparam int I_ACLR = 3;
  localparam int I_AZR  = 4;
  localparam int I_BWR  = 5;
  localparam int I_BRD  = 6;
  localparam int I_BCLR = 7;
  localparam int I_BZR  = 8;
  localparam int I_END  = 9;

  typedef enum logic [9:0] {
    IDLE  = 10'b00_0000_0001,
    A_WR  = 10'b00_0000_0010,
    A_RD  = 10'b00_0000_0100,
    A_CLR = 10'b00_0000_1000,
    A_ZR  = 10'b00_0001_0000,
    B_WR  = 10'b00_0010_0000,
    B_RD  = 10'b00_0100_0000,
    B_CLR = 10'b00_1000_0000,
    B_ZR  = 10'b01_0000_0000,
    END   = 10'b10_0000_0000
  } state_t;

  localparam logic PH_DRIVE = 1'b0;
  localparam logic PH_CHECK = 1'b1;

endpackage

// File: rtl/iob_regfile_dp_bist_sweep.sv
// Address counter plus drive/check phase bit for one regfile sweep.
module iob_regfile_dp_bist_sweep
  import iob_regfile_dp_bist_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              phase,
  output logic              last,
  output logic [ADDR_W-1:0] addrNxt,
  output logic              phaseNxt
);

  always_comb begin
    addrNxt  = addr;
    phaseNxt = phase;
    if (clr) begin
      addrNxt  = '0;
      phaseNxt = PH_DRIVE;
    end else if (en) begin
      if (phase == PH_CHECK) begin
        addrNxt  = addr + 1'b1;
        phaseNxt = PH_DRIVE;
      end else begin
        phaseNxt = PH_CHECK;
      end
    end
  end

  assign last = (phase == PH_CHECK) &&
                (addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      phase <= PH_DRIVE;
    end else begin
      addr  <= addrNxt;
      phase <= phaseNxt;
    end
  end

endmodule

// File: rtl/iob_regfile_dp_bist.sv
// BIST initiator for iob_regfile_dp: write, retention, clear and
// zero-check sweeps on port A then port B, with first-failure capture.
module iob_regfile_dp_bist
  import iob_regfile_dp_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int SEED_A = 32,
  parameter int SEED_B = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_port,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic              rf_rst,
  output logic [ADDR_W-1:0] rf_addrA,
  output logic [DATA_W-1:0] rf_wdataA,
  output logic              rf_weA,
  input  logic [DATA_W-1:0] rf_rdataA,
  output logic [ADDR_W-1:0] rf_addrB,
  output logic [DATA_W-1:0] rf_wdataB,
  output logic              rf_weB,
  input  logic [DATA_W-1:0] rf_rdataB
);

  state_t state, stateNxt;

  logic [ADDR_W-1:0] addr, addrNxt;
  logic              phase, phaseNxt, last;
  logic              swEn, swClr;
  logic              inA, inB, swp, zr, miss;
  logic              accept, drv, rstNxt;
  logic [DATA_W-1:0] seed, expd, rdata;

  logic [ADDR_W-1:0] addrANxt, addrBNxt;
  logic [DATA_W-1:0] wdANxt, wdBNxt;
  logic              weANxt, weBNxt;

  iob_regfile_dp_bist_sweep #(
    .ADDR_W(ADDR_W)
  ) u_sweep (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (swClr),
    .en      (swEn),
    .addr    (addr),
    .phase   (phase),
    .last    (last),
    .addrNxt (addrNxt),
    .phaseNxt(phaseNxt)
  );

  assign inA = state[I_AWR] | state[I_ARD] | state[I_AZR];
  assign inB = state[I_BWR] | state[I_BRD] | state[I_BZR];
  assign swp = inA | inB;
  assign zr  = state[I_AZR] | state[I_BZR];

  assign seed  = inB ? DATA_W'(SEED_B) : DATA_W'(SEED_A);
  assign expd  = zr ? '0 : seed + DATA_W'(addr);
  assign rdata = inB ? rf_rdataB : rf_rdataA;
  assign miss  = swp && (phase == PH_CHECK) &&
                 (rdata != expd);

  assign swEn   = swp & ~miss;
  assign swClr  = miss;
  assign accept = state[I_IDLE] & start;

  always_comb begin
    stateNxt = state;
    unique case (1'b1)
      state[I_IDLE]: if (start) stateNxt = A_WR;
      state[I_AWR]:  if (last) stateNxt = A_RD;
      state[I_ARD]:  if (last) stateNxt = A_CLR;
      state[I_ACLR]: stateNxt = A_ZR;
      state[I_AZR]:  if (last) stateNxt = B_WR;
      state[I_BWR]:  if (last) stateNxt = B_RD;
      state[I_BRD]:  if (last) stateNxt = B_CLR;
      state[I_BCLR]: stateNxt = B_ZR;
      state[I_BZR]:  if (last) stateNxt = END;
      state[I_END]:  stateNxt = IDLE;
      default:       stateNxt = IDLE;
    endcase
    if (miss) stateNxt = END;
  end

  // Port values for the coming cycle, so every regfile pin is a flop.
  always_comb begin
    addrANxt = '0;
    addrBNxt = '0;
    weANxt   = 1'b0;
    weBNxt   = 1'b0;
    wdANxt   = '0;
    wdBNxt   = '0;
    drv      = (phaseNxt == PH_DRIVE);
    rstNxt   = stateNxt[I_ACLR] | stateNxt[I_BCLR];
    if (stateNxt[I_AWR] | stateNxt[I_ARD] |
        stateNxt[I_AZR]) begin
      addrANxt = addrNxt;
      weANxt   = stateNxt[I_AWR] & drv;
    end
    if (stateNxt[I_BWR] | stateNxt[I_BRD] |
        stateNxt[I_BZR]) begin
      addrBNxt = addrNxt;
      weBNxt   = stateNxt[I_BWR] & drv;
    end
    if (weANxt)
      wdANxt = DATA_W'(SEED_A) + DATA_W'(addrNxt);
    if (weBNxt)
      wdBNxt = DATA_W'(SEED_B) + DATA_W'(addrNxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf_rst    <= 1'b0;
      rf_addrA  <= '0;
      rf_wdataA <= '0;
      rf_weA    <= 1'b0;
      rf_addrB  <= '0;
      rf_wdataB <= '0;
      rf_weB    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNxt;
      rf_rst    <= rstNxt;
      rf_addrA  <= addrANxt;
      rf_wdataA <= wdANxt;
      rf_weA    <= weANxt;
      rf_addrB  <= addrBNxt;
      rf_wdataB <= wdBNxt;
      rf_weB    <= weBNxt;
      busy      <= ~(stateNxt[I_IDLE] |
                     stateNxt[I_END]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      err_port <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else if (accept) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      err_port <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else begin
      if (stateNxt[I_END]) begin
        done <= 1'b1;
        pass <= ~miss;
      end
      if (miss) begin
        err_port <= inB;
        err_addr <= addr;
        err_data <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_iob_regfile_dp_bist.sv
// Bench: behavioural dual-port regfile with fault hooks plus a
// sweep-level reference model of the expected BIST outcome.
module tb_iob_regfile_dp_bist;

  typedef struct packed {
    bit          pass;
    bit          port;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
    int          busy;
    int          rst;
    logic [3:0]  cl;
    int          viol;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, pass, err_port;
  logic [3:0]  err_addr;
  logic [31:0] err_data;
  logic        rf_rst;
  logic [3:0]  rf_addrA, rf_addrB;
  logic [31:0] rf_wdataA, rf_wdataB;
  logic        rf_weA, rf_weB;
  logic [31:0] rf_rdataA, rf_rdataB;

  int nVec = 0;
  int nMiss = 0;

  bit       stEn, stVal, ckEn, biEn;
  logic [3:0] stAddr, ckAddr, biAddr;
  int       stBit;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  iob_regfile_dp_bist dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_port (err_port),
    .err_addr (err_addr),
    .err_data (err_data),
    .rf_rst   (rf_rst),
    .rf_addrA (rf_addrA),
    .rf_wdataA(rf_wdataA),
    .rf_weA   (rf_weA),
    .rf_rdataA(rf_rdataA),
    .rf_addrB (rf_addrB),
    .rf_wdataB(rf_wdataB),
    .rf_weB   (rf_weB),
    .rf_rdataB(rf_rdataB)
  );

  // Regfile model: synchronous clear/write, combinational read.
  always_ff @(posedge clk) begin
    if (rf_rst) begin
      for (int j = 0; j < 16; j++)
        if (!(ckEn && j == ckAddr)) mem[j] <= '0;
    end else begin
      if (rf_weA) mem[rf_addrA] <= rf_wdataA;
      if (rf_weB && !(biEn && rf_addrB == biAddr))
        mem[rf_addrB] <= rf_wdataB;
    end
  end

  always_comb begin
    rf_rdataA = mem[rf_addrA];
    rf_rdataB = mem[rf_addrB];
    if (stEn && rf_addrA == stAddr) rf_rdataA[stBit] = stVal;
    if (stEn && rf_addrB == stAddr) rf_rdataB[stBit] = stVal;
  end

  function automatic string fmt(res_t r);
    return $sformatf(
      "pass=%0d port=%0d addr=%0d data=%0d cyc=%0d busy=%0d rst=%0d cl=%b viol=%0d",
      r.pass, r.port, r.addr, r.data, r.cyc, r.busy,
      r.rst, r.cl, r.viol);
  endfunction

  task automatic noFaults();
    stEn = 0; ckEn = 0; biEn = 0;
    stVal = 0; stBit = 0;
    stAddr = '0; ckAddr = '0; biAddr = '0;
  endtask

  // Expected outcome from the sweep rules applied to an array.
  task automatic refRun(output res_t e);
    logic [31:0] mm [16];
    logic [31:0] seed, ex, v;
    int c;
    bit stop;
    e = '0; c = 0; stop = 0;
    for (int j = 0; j < 16; j++) mm[j] = '0;
    for (int p = 0; p < 2 && !stop; p++) begin
      seed = (p == 1) ? 32'd64 : 32'd32;
      for (int s = 0; s < 3 && !stop; s++) begin
        if (s == 2) begin
          c++; e.rst++;
          for (int j = 0; j < 16; j++)
            if (!(ckEn && j == ckAddr)) mm[j] = '0;
        end
        for (int i = 0; i < 16 && !stop; i++) begin
          c += 2;
          if (s == 0 && !(p == 1 && biEn && i == biAddr))
            mm[i] = seed + i;
          v = mm[i];
          if (stEn && i == stAddr) v[stBit] = stVal;
          ex = (s < 2) ? seed + i : 32'd0;
          if (v !== ex) begin
            stop = 1;
            e.port = p[0];
            e.addr = i[3:0];
            e.data = v;
          end
        end
      end
    end
    e.pass = !stop;
    e.cyc  = c + 1;
    e.busy = c;
    e.cl   = 4'b0001;
    e.viol = 0;
  endtask

  // Pulse start, follow the run to done (bounded), collect observations.
  task automatic runBist(input int dupAt, output res_t r);
    int k;
    r = '0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    r.cl = {done, pass,
            err_port | (|err_addr) | (|err_data), busy};
    k = 1;
    forever begin
      if (busy) r.busy++;
      if (rf_rst) r.rst++;
      if (k <= 97) begin
        if (rf_weB || rf_addrB != 0) r.viol++;
      end else if (rf_weA || rf_addrA != 0) r.viol++;
      if (done || k >= 1000) break;
      start = (k == dupAt);
      @(negedge clk); k++;
    end
    start = 0;
    r.cyc  = done ? k : -1;
    r.pass = pass;
    r.port = err_port;
    r.addr = err_addr;
    r.data = err_data;
  endtask

  task automatic test_reset();
    rst_n = 1; start = 0;
    #3 rst_n = 0;
    #2;
    nVec++;
    if ({busy, done, pass, err_port, err_addr, err_data,
         rf_rst, rf_addrA, rf_wdataA, rf_weA,
         rf_addrB, rf_wdataB, rf_weB} !== '0) begin
      nMiss++;
      $display("FAIL reset: outputs not all zero (busy=%b done=%b rf_rst=%b)",
               busy, done, rf_rst);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fault_free();
    res_t o, e;
    noFaults();
    refRun(e);
    runBist(0, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL fault_free: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_stuck_bit();
    res_t o, e;
    noFaults();
    stEn = 1; stAddr = 4'd5; stBit = 2; stVal = 0;
    refRun(e);
    runBist(0, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL stuck_bit: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_clear_miss();
    res_t o, e;
    noFaults();
    ckEn = 1; ckAddr = 4'd15;
    refRun(e);
    runBist(0, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL clear_miss: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_b_write();
    res_t o, e;
    noFaults();
    biEn = 1; biAddr = 4'd2;
    refRun(e);
    runBist(0, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL b_write: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_abort();
    res_t o, e;
    logic wasBusy;
    noFaults();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (39) @(negedge clk);
    wasBusy = busy;
    #2 rst_n = 0;
    #1;
    nVec++;
    if (wasBusy !== 1'b1) begin
      nMiss++;
      $display("FAIL abort_busy: busy=%b want 1", wasBusy);
    end
    nVec++;
    if ({busy, done, pass, err_port, err_addr, err_data,
         rf_rst, rf_addrA, rf_wdataA, rf_weA,
         rf_addrB, rf_wdataB, rf_weB} !== '0) begin
      nMiss++;
      $display("FAIL abort_zero: busy=%b done=%b weA=%b addrA=%0d want all 0",
               busy, done, rf_weA, rf_addrA);
    end
    @(negedge clk); rst_n = 1;
    refRun(e);
    runBist(0, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL abort_rerun: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_restart();
    res_t o, e;
    noFaults();
    refRun(e);
    runBist(50, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL start_busy: got %s want %s", fmt(o), fmt(e));
    end
    repeat (3) @(negedge clk);
    nVec++;
    if ({done, pass, busy} !== 3'b110) begin
      nMiss++;
      $display("FAIL done_hold: done/pass/busy=%b want 110",
               {done, pass, busy});
    end
    runBist(0, o);
    nVec++;
    if (o !== e) begin
      nMiss++;
      $display("FAIL start_done: got %s want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_random();
    res_t o, e;
    for (int n = 0; n < 8; n++) begin
      noFaults();
      case ($urandom_range(0, 3))
        1: begin
          stEn = 1; stAddr = 4'($urandom_range(0, 15));
          stBit = $urandom_range(0, 31);
          stVal = 1'($urandom_range(0, 1));
        end
        2: begin
          ckEn = 1; ckAddr = 4'($urandom_range(0, 15));
        end
        3: begin
          biEn = 1; biAddr = 4'($urandom_range(0, 15));
        end
        default: ;
      endcase
      repeat ($urandom_range(0, 5)) @(negedge clk);
      refRun(e);
      runBist(0, o);
      nVec++;
      if (o !== e) begin
        nMiss++;
        $display("FAIL random_%0d: got %s want %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    noFaults();
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_clear_miss();
    test_b_write();
    test_abort();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
